rs_issue_select: RTL

- Issue stage directly downstream of the reservation-station lines.
- Each cycle, picks up to WAYS ready RS entries in round-robin order and asserts their per-line clear so the RS frees them.
- Registers the picked entries into per-lane issue/execute pipeline registers with a valid/ready handshake toward the functional units.
- Flushes all in-flight issue state on squash.

---
 rtl/rs_issue_select_pkg.sv | 93 +++++++++
 rtl/rs_issue_select_rr_pick.sv | 43 ++++
 rtl/rs_issue_select.sv | 80 ++++++++
 3 files changed

// File: rtl/rs_issue_select_pkg.sv
// Shared types and constants for the RS issue-select block.
//   rs_line_t       : one reservation-station line as presented to issue
//   is_ex_packet_t  : issue/execute pipeline payload (RS line minus RS bookkeeping)
//   to_packet       : strips RS-only fields from a line
//   count_ones      : popcount over the issue lanes
package rs_issue_select_pkg;

   localparam int unsigned RSLEN = 8;
   localparam int unsigned WAYS  = 3;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNTW  = 32;
   localparam int unsigned PTRW  = $clog2(RSLEN);
   localparam int unsigned CNTLW = $clog2(WAYS + 1);
   localparam int unsigned INSTW = 32;
   localparam int unsigned TAGW  = 5;
   localparam int unsigned REGW  = 5;
   localparam int unsigned FUNCW = 5;

   localparam logic [INSTW-1:0] NOP_INST = 32'h0000_0013;
   localparam logic [REGW-1:0]  ZERO_REG = '0;

   typedef struct packed {
      logic [INSTW-1:0] inst;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  npc;
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
      logic [TAGW-1:0]  t;
      logic [REGW-1:0]  dest_reg;
      logic [FUNCW-1:0] alu_func;
      logic             rd_mem;
      logic             wr_mem;
      logic             cond_branch;
      logic             uncond_branch;
      logic             halt;
      logic             illegal;
      logic             valid;
   } is_ex_packet_t;

   typedef struct packed {
      logic [PTRW-1:0]  rsid;
      logic             busy;
      logic [TAGW-1:0]  t1;
      logic [TAGW-1:0]  t2;
      logic             valid1;
      logic             valid2;
      logic [INSTW-1:0] inst;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  npc;
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
      logic [TAGW-1:0]  t;
      logic [REGW-1:0]  dest_reg;
      logic [FUNCW-1:0] alu_func;
      logic             rd_mem;
      logic             wr_mem;
      logic             cond_branch;
      logic             uncond_branch;
      logic             halt;
      logic             illegal;
      logic             valid;
   } rs_line_t;

   localparam is_ex_packet_t PKT_RESET = '{inst: NOP_INST, dest_reg: ZERO_REG, default: '0};

   function automatic is_ex_packet_t to_packet(input rs_line_t l);
      is_ex_packet_t p;
      p.inst          = l.inst;
      p.pc            = l.pc;
      p.npc           = l.npc;
      p.v1            = l.v1;
      p.v2            = l.v2;
      p.t             = l.t;
      p.dest_reg      = l.dest_reg;
      p.alu_func      = l.alu_func;
      p.rd_mem        = l.rd_mem;
      p.wr_mem        = l.wr_mem;
      p.cond_branch   = l.cond_branch;
      p.uncond_branch = l.uncond_branch;
      p.halt          = l.halt;
      p.illegal       = l.illegal;
      p.valid         = l.valid;
      return p;
   endfunction

   function automatic logic [CNTLW-1:0] count_ones(input logic [WAYS-1:0] v);
      logic [CNTLW-1:0] c;
      c = '0;
      for (int k = 0; k < WAYS; k++) c = c + CNTLW'(v[k]);
      return c;
   endfunction

endpackage

// File: rtl/rs_issue_select_rr_pick.sv
// Rotating-base multi-grant priority encoder.
//   req       : per-line request
//   base      : scan start index (wraps modulo RSLEN)
//   free      : per-lane availability
//   grant_idx : picked line per lane
//   grant_vld : lane received a pick
//   last_idx  : index of the last line picked in scan order (valid when any grant)
module rs_issue_select_rr_pick
   import rs_issue_select_pkg::*;
(
   input  logic [RSLEN-1:0]           req,
   input  logic [PTRW-1:0]            base,
   input  logic [WAYS-1:0]            free,
   output logic [WAYS-1:0][PTRW-1:0]  grant_idx,
   output logic [WAYS-1:0]            grant_vld,
   output logic [PTRW-1:0]            last_idx
);

   logic [PTRW-1:0] idx;
   logic            placed;

   // Walk lines from base; each requesting line takes the lowest free, unfilled lane.
   always_comb begin
      grant_idx = '0;
      grant_vld = '0;
      last_idx  = '0;
      idx       = '0;
      placed    = 1'b0;
      for (int j = 0; j < RSLEN; j++) begin
         idx    = base + PTRW'(j);
         placed = 1'b0;
         for (int k = 0; k < WAYS; k++) begin
            if (req[idx] && free[k] && !grant_vld[k] && !placed) begin
               grant_vld[k] = 1'b1;
               grant_idx[k] = idx;
               last_idx     = idx;
               placed       = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rs_issue_select.sv
// Issue stage: picks up to WAYS ready RS lines round-robin, clears them in the RS,
// and holds them in per-lane issue/execute registers with a valid/ready handshake.
//   clock, reset (async active-low), squash (sync flush)
//   rs_lines, not_ready : RS line contents and per-line not-ready
//   ex_ready            : per-lane consume from the functional units
//   clear_mask          : combinational per-line clear for lines picked this cycle
//   issue_valid, is_ex_packet : registered lane outputs
//   issued_total        : wrapping count of packets consumed by the FUs
module rs_issue_select
   import rs_issue_select_pkg::*;
(
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        squash,
   input  rs_line_t [RSLEN-1:0]        rs_lines,
   input  logic [RSLEN-1:0]            not_ready,
   input  logic [WAYS-1:0]             ex_ready,
   output logic [RSLEN-1:0]            clear_mask,
   output logic [WAYS-1:0]             issue_valid,
   output is_ex_packet_t [WAYS-1:0]    is_ex_packet,
   output logic [CNTW-1:0]             issued_total
);

   logic [PTRW-1:0]           rr_ptr;
   logic [RSLEN-1:0]          req;
   logic [WAYS-1:0]           free;
   logic [WAYS-1:0][PTRW-1:0] grant_idx;
   logic [WAYS-1:0]           grant_vld;
   logic [PTRW-1:0]           last_idx;

   // Candidates are suppressed during reset and squash so nothing is picked or cleared.
   always_comb begin
      req = '0;
      for (int i = 0; i < RSLEN; i++) begin
         req[i] = rs_lines[i].busy & ~not_ready[i] & reset & ~squash;
      end
   end

   // No skid buffer: a lane accepts a new packet only if empty or draining now.
   assign free = ~issue_valid | ex_ready;

   rs_issue_select_rr_pick u_pick (
      .req       (req),
      .base      (rr_ptr),
      .free      (free),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld),
      .last_idx  (last_idx)
   );

   // Per-line clear for every granted line.
   always_comb begin
      clear_mask = '0;
      for (int k = 0; k < WAYS; k++) begin
         if (grant_vld[k]) clear_mask[grant_idx[k]] = 1'b1;
      end
   end

   // Lane registers, round-robin pointer and issue counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         issue_valid  <= '0;
         is_ex_packet <= {WAYS{PKT_RESET}};
         rr_ptr       <= '0;
         issued_total <= '0;
      end else if (squash) begin
         issue_valid  <= '0;
      end else begin
         issued_total <= issued_total + CNTW'(count_ones(issue_valid & ex_ready));
         for (int k = 0; k < WAYS; k++) begin
            if (free[k]) begin
               issue_valid[k] <= grant_vld[k];
               if (grant_vld[k]) is_ex_packet[k] <= to_packet(rs_lines[grant_idx[k]]);
            end
         end
         if (|grant_vld) rr_ptr <= last_idx + PTRW'(1);
      end
   end

endmodule
